// File: rtl/fsm_ctrl.sv
// fsm_ctrl: control state machine for the FIFO interconnect.
// Captures per-FIFO almost-empty/almost-full thresholds while in INIT,
// republishes them as registered copies, and tracks the empties/errors
// status vectors to report IDLE, ACTIVE or ERROR.
module fsm_ctrl #(
  parameter int unsigned NUM_FIFOS = 5,
  parameter int unsigned TH_W      = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [TH_W-1:0]      main_fifo_low,
  input  logic [TH_W-1:0]      main_fifo_high,
  input  logic [TH_W-1:0]      Vco_low,
  input  logic [TH_W-1:0]      Vco_high,
  input  logic [TH_W-1:0]      Vc1_low,
  input  logic [TH_W-1:0]      Vc1_high,
  input  logic [TH_W-1:0]      Do_low,
  input  logic [TH_W-1:0]      Do_high,
  input  logic [TH_W-1:0]      D1_low,
  input  logic [TH_W-1:0]      D1_high,
  input  logic [NUM_FIFOS-1:0] empties,
  input  logic [NUM_FIFOS-1:0] errors,
  output logic [TH_W-1:0]      main_fifo_low_q,
  output logic [TH_W-1:0]      main_fifo_high_q,
  output logic [TH_W-1:0]      Vco_low_q,
  output logic [TH_W-1:0]      Vco_high_q,
  output logic [TH_W-1:0]      Vc1_low_q,
  output logic [TH_W-1:0]      Vc1_high_q,
  output logic [TH_W-1:0]      Do_low_q,
  output logic [TH_W-1:0]      Do_high_q,
  output logic [TH_W-1:0]      D1_low_q,
  output logic [TH_W-1:0]      D1_high_q,
  output logic [2:0]           state,
  output logic                 idle_out,
  output logic                 active_out,
  output logic                 error_out,
  output logic [NUM_FIFOS-1:0] err_latched,
  output logic                 cfg_err
);

  localparam int unsigned NUM_PAIRS = 5;
  localparam int unsigned NUM_TH    = 2 * NUM_PAIRS;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  // Thresholds are handled as an array: even index = low, odd index = high.
  logic [TH_W-1:0]      th_in [NUM_TH];
  logic [TH_W-1:0]      th_q  [NUM_TH];
  logic [TH_W-1:0]      th_d  [NUM_TH];

  state_e               state_q, state_d;
  logic [NUM_FIFOS-1:0] err_latched_q, err_latched_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 idle_q, active_q, error_q;
  logic                 cfg_ok;

  assign th_in[0] = main_fifo_low;
  assign th_in[1] = main_fifo_high;
  assign th_in[2] = Vco_low;
  assign th_in[3] = Vco_high;
  assign th_in[4] = Vc1_low;
  assign th_in[5] = Vc1_high;
  assign th_in[6] = Do_low;
  assign th_in[7] = Do_high;
  assign th_in[8] = D1_low;
  assign th_in[9] = D1_high;

  // Configuration is legal when every pair being loaded has low <= high (unsigned).
  always_comb begin
    cfg_ok = 1'b1;
    for (int unsigned p = 0; p < NUM_PAIRS; p++) begin
      if (th_in[2*p] > th_in[2*p+1]) begin
        cfg_ok = 1'b0;
      end
    end
  end

  // Next-state, threshold load, sticky error and config-error logic.
  always_comb begin
    state_d       = state_q;
    th_d          = th_q;
    err_latched_d = err_latched_q;
    cfg_err_d     = cfg_err_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_INIT;
      end
      ST_INIT: begin
        // Load every edge in INIT, including the exit edge.
        th_d = th_in;
        if (!init) begin
          if (cfg_ok) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_ERROR;
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        err_latched_d = err_latched_q | errors;
        if (|errors) begin
          state_d = ST_ERROR;
        end else if (init) begin
          state_d = ST_INIT;
        end else if (!(&empties)) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        err_latched_d = err_latched_q | errors;
        if (|errors) begin
          state_d = ST_ERROR;
        end else if (init) begin
          state_d = ST_INIT;
        end else if (&empties) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: begin
        // Absorbing; only reset leaves ERROR.
        err_latched_d = err_latched_q | errors;
      end
      default: begin
        // Unused encodings recover into ERROR.
        state_d = ST_ERROR;
      end
    endcase
  end

  // State register plus registered one-hot status decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RESET;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= (state_d == ST_IDLE);
      active_q <= (state_d == ST_ACTIVE);
      error_q  <= (state_d == ST_ERROR);
    end
  end

  // Threshold copy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_TH; i++) begin
        th_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_TH; i++) begin
        th_q[i] <= th_d[i];
      end
    end
  end

  // Sticky status registers, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_latched_q <= '0;
      cfg_err_q     <= 1'b0;
    end else begin
      err_latched_q <= err_latched_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign state            = state_q;
  assign idle_out         = idle_q;
  assign active_out       = active_q;
  assign error_out        = error_q;
  assign err_latched      = err_latched_q;
  assign cfg_err          = cfg_err_q;

  assign main_fifo_low_q  = th_q[0];
  assign main_fifo_high_q = th_q[1];
  assign Vco_low_q        = th_q[2];
  assign Vco_high_q       = th_q[3];
  assign Vc1_low_q        = th_q[4];
  assign Vc1_high_q       = th_q[5];
  assign Do_low_q         = th_q[6];
  assign Do_high_q        = th_q[7];
  assign D1_low_q         = th_q[8];
  assign D1_high_q        = th_q[9];

endmodule

// File: tb/tb_fsm_ctrl.sv
// Bench for fsm_ctrl: a directed vector table, hand-written multi-cycle
// sequences, then randomized traffic checked against a behavioural model.
module tb_fsm_ctrl;

  logic        clk;
  logic        reset;
  logic        init;
  logic [4:0]  empties;
  logic [4:0]  errors;
  logic [49:0] th_in;
  logic [49:0] th_out;

  logic [4:0]  main_fifo_low_q, main_fifo_high_q, Vco_low_q, Vco_high_q;
  logic [4:0]  Vc1_low_q, Vc1_high_q, Do_low_q, Do_high_q, D1_low_q, D1_high_q;
  logic [2:0]  state;
  logic        idle_out, active_out, error_out, cfg_err;
  logic [4:0]  err_latched;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: state number, sticky errors, cfg flag, loaded thresholds.
  int          mstate;
  logic [4:0]  merr;
  logic        mcfg;
  logic [49:0] mth;

  fsm_ctrl #(.NUM_FIFOS(5), .TH_W(5)) dut (
    .clk(clk), .reset(reset), .init(init),
    .main_fifo_low(th_in[4:0]),   .main_fifo_high(th_in[9:5]),
    .Vco_low(th_in[14:10]),       .Vco_high(th_in[19:15]),
    .Vc1_low(th_in[24:20]),       .Vc1_high(th_in[29:25]),
    .Do_low(th_in[34:30]),        .Do_high(th_in[39:35]),
    .D1_low(th_in[44:40]),        .D1_high(th_in[49:45]),
    .empties(empties), .errors(errors),
    .main_fifo_low_q(main_fifo_low_q), .main_fifo_high_q(main_fifo_high_q),
    .Vco_low_q(Vco_low_q), .Vco_high_q(Vco_high_q),
    .Vc1_low_q(Vc1_low_q), .Vc1_high_q(Vc1_high_q),
    .Do_low_q(Do_low_q),   .Do_high_q(Do_high_q),
    .D1_low_q(D1_low_q),   .D1_high_q(D1_high_q),
    .state(state), .idle_out(idle_out), .active_out(active_out),
    .error_out(error_out), .err_latched(err_latched), .cfg_err(cfg_err)
  );

  assign th_out = {D1_high_q, D1_low_q, Do_high_q, Do_low_q, Vc1_high_q, Vc1_low_q,
                   Vco_high_q, Vco_low_q, main_fifo_high_q, main_fifo_low_q};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        init;
    logic [4:0]  empties;
    logic [4:0]  errors;
    logic [49:0] th;
    logic [2:0]  es;
    logic [4:0]  ee;
    logic        ec;
    logic [49:0] et;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [49:0] mk_th(
      input logic [4:0] ml, input logic [4:0] mh, input logic [4:0] v0l, input logic [4:0] v0h,
      input logic [4:0] v1l, input logic [4:0] v1h, input logic [4:0] d0l, input logic [4:0] d0h,
      input logic [4:0] d1l, input logic [4:0] d1h);
    return {d1h, d1l, d0h, d0l, v1h, v1l, v0h, v0l, mh, ml};
  endfunction

  function automatic vec_t mk_vec(input logic i, input logic [4:0] e, input logic [4:0] er,
                                  input logic [49:0] t, input logic [2:0] es,
                                  input logic [4:0] ee, input logic ec, input logic [49:0] et);
    vec_t v;
    v.init = i; v.empties = e; v.errors = er; v.th = t;
    v.es = es; v.ee = ee; v.ec = ec; v.et = et;
    return v;
  endfunction

  task automatic drive(input logic i, input logic [4:0] e, input logic [4:0] er,
                       input logic [49:0] t);
    init = i; empties = e; errors = er; th_in = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] es, input logic [4:0] ee,
                       input logic ec, input logic [49:0] et);
    n_vec++;
    if (state !== es) begin
      n_mis++; $display("FAIL %s state: got %0d want %0d", tag, state, es);
    end
    if (idle_out !== (es == 3'd2)) begin
      n_mis++; $display("FAIL %s idle_out: got %b want %b", tag, idle_out, es == 3'd2);
    end
    if (active_out !== (es == 3'd3)) begin
      n_mis++; $display("FAIL %s active_out: got %b want %b", tag, active_out, es == 3'd3);
    end
    if (error_out !== (es == 3'd4)) begin
      n_mis++; $display("FAIL %s error_out: got %b want %b", tag, error_out, es == 3'd4);
    end
    if (err_latched !== ee) begin
      n_mis++; $display("FAIL %s err_latched: got %b want %b", tag, err_latched, ee);
    end
    if (cfg_err !== ec) begin
      n_mis++; $display("FAIL %s cfg_err: got %b want %b", tag, cfg_err, ec);
    end
    if (th_out !== et) begin
      n_mis++; $display("FAIL %s thresholds: got %h want %h", tag, th_out, et);
    end
  endtask

  task automatic model_reset();
    mstate = 0; merr = '0; mcfg = 1'b0; mth = '0;
  endtask

  // One clock edge of the behavioural model, from the currently driven inputs.
  task automatic model_edge();
    bit ok;
    ok = 1'b1;
    for (int p = 0; p < 5; p++) begin
      if (th_in[10*p +: 5] > th_in[10*p+5 +: 5]) ok = 1'b0;
    end
    if (mstate >= 2 && mstate <= 4) merr = merr | errors;
    case (mstate)
      0: mstate = 1;
      1: begin
        mth = th_in;
        if (!init) begin
          mstate = ok ? 2 : 4;
          if (!ok) mcfg = 1'b1;
        end
      end
      2, 3: begin
        if (errors != 5'd0)       mstate = 4;
        else if (init)            mstate = 1;
        else if (empties == 5'h1F) mstate = 2;
        else                      mstate = 3;
      end
      default: ;
    endcase
  endtask

  task automatic check_model(input string tag);
    check(tag, 3'(mstate), merr, mcfg, mth);
  endtask

  // Assert reset between edges, check it took effect before the next posedge.
  task automatic async_reset(input string tag);
    reset = 1'b1;
    #2;
    check(tag, 3'd0, 5'd0, 1'b0, 50'd0);
    tick();
    reset = 1'b0;
  endtask

  logic [49:0] TH_A, TH_B, TH_C, TH_EQ;

  initial begin
    logic [4:0] lo, hi, tmp;

    TH_A  = mk_th(5'd3, 5'd12, 5'd0, 5'd31, 5'd0, 5'd31, 5'd1, 5'd1, 5'd0, 5'd31);
    TH_B  = mk_th(5'd3, 5'd12, 5'd0, 5'd31, 5'd0, 5'd31, 5'd1, 5'd1, 5'd0, 5'd20);
    TH_C  = mk_th(5'd3, 5'd12, 5'd9, 5'd4,  5'd0, 5'd31, 5'd1, 5'd1, 5'd0, 5'd20);
    TH_EQ = mk_th(5'd31, 5'd31, 5'd0, 5'd0, 5'd17, 5'd17, 5'd31, 5'd31, 5'd5, 5'd5);

    //              init  empties  errors   th    state  err      cfg   th_q
    vecs[0]  = mk_vec(1'b1, 5'h1F, 5'h00,  TH_A, 3'd1, 5'h00, 1'b0, 50'd0);
    vecs[1]  = mk_vec(1'b1, 5'h1F, 5'h00,  TH_A, 3'd1, 5'h00, 1'b0, TH_A);
    vecs[2]  = mk_vec(1'b0, 5'h1F, 5'h00,  TH_A, 3'd2, 5'h00, 1'b0, TH_A);
    vecs[3]  = mk_vec(1'b0, 5'h1E, 5'h00,  TH_A, 3'd3, 5'h00, 1'b0, TH_A);
    vecs[4]  = mk_vec(1'b0, 5'h1F, 5'h00,  TH_A, 3'd2, 5'h00, 1'b0, TH_A);
    vecs[5]  = mk_vec(1'b0, 5'h1F, 5'h00,  TH_A, 3'd2, 5'h00, 1'b0, TH_A);
    vecs[6]  = mk_vec(1'b1, 5'h0F, 5'h00,  TH_A, 3'd1, 5'h00, 1'b0, TH_A);
    vecs[7]  = mk_vec(1'b1, 5'h0F, 5'h00,  TH_B, 3'd1, 5'h00, 1'b0, TH_B);
    vecs[8]  = mk_vec(1'b0, 5'h1F, 5'h01,  TH_C, 3'd4, 5'h00, 1'b1, TH_C);
    vecs[9]  = mk_vec(1'b1, 5'h00, 5'h04,  TH_B, 3'd4, 5'h04, 1'b1, TH_C);
    vecs[10] = mk_vec(1'b0, 5'h1E, 5'h00,  TH_A, 3'd4, 5'h04, 1'b1, TH_C);

    reset = 1'b1;
    drive(1'b0, 5'h1F, 5'h00, 50'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 3'd0, 5'd0, 1'b0, 50'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].init, vecs[i].empties, vecs[i].errors, vecs[i].th);
      tick();
      check($sformatf("vec%0d", i), vecs[i].es, vecs[i].ee, vecs[i].ec, vecs[i].et);
    end

    // Reset aborts ERROR.
    async_reset("rst_from_error");

    // Errors beat init, ERROR is sticky and ignores init.
    drive(1'b1, 5'h1F, 5'h00, TH_A); tick(); check("t5_init",   3'd1, 5'h00, 1'b0, 50'd0);
    drive(1'b0, 5'h1F, 5'h00, TH_A); tick(); check("t5_idle",   3'd2, 5'h00, 1'b0, TH_A);
    drive(1'b0, 5'h1E, 5'h00, TH_A); tick(); check("t5_active", 3'd3, 5'h00, 1'b0, TH_A);
    drive(1'b1, 5'h1E, 5'h04, TH_A); tick(); check("t5_error",  3'd4, 5'h04, 1'b0, TH_A);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'h1F, 5'h00, TH_B); tick();
      check($sformatf("t5_hold%0d", i), 3'd4, 5'h04, 1'b0, TH_A);
    end
    async_reset("t5_reset");

    // Re-init from ACTIVE picks up new thresholds on the INIT exit edge.
    drive(1'b1, 5'h1F, 5'h00, TH_A); tick(); check("t6_init",    3'd1, 5'h00, 1'b0, 50'd0);
    drive(1'b0, 5'h1F, 5'h00, TH_A); tick(); check("t6_idle",    3'd2, 5'h00, 1'b0, TH_A);
    drive(1'b0, 5'h1E, 5'h00, TH_A); tick(); check("t6_active",  3'd3, 5'h00, 1'b0, TH_A);
    drive(1'b1, 5'h1E, 5'h00, TH_B); tick(); check("t6_reinit",  3'd1, 5'h00, 1'b0, TH_A);
    drive(1'b0, 5'h1E, 5'h00, TH_B); tick(); check("t6_idle2",   3'd2, 5'h00, 1'b0, TH_B);
    drive(1'b0, 5'h1E, 5'h00, TH_B); tick(); check("t6_active2", 3'd3, 5'h00, 1'b0, TH_B);
    // Async reset from ACTIVE clears everything before the next edge.
    async_reset("t1_async");

    // Single INIT cycle with all pairs equal (incl. 0/0 and 31/31) is legal.
    drive(1'b0, 5'h1F, 5'h00, TH_EQ); tick(); check("eq_init", 3'd1, 5'h00, 1'b0, 50'd0);
    tick(); check("eq_idle", 3'd2, 5'h00, 1'b0, TH_EQ);

    // Randomized traffic against the behavioural model.
    async_reset("rnd_start");
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(39) == 0) begin
        reset = 1'b1;
        #2;
        model_reset();
        check_model("rnd_async");
        tick();
        check_model("rnd_rst_edge");
        reset = 1'b0;
      end else begin
        for (int p = 0; p < 5; p++) begin
          lo = 5'($urandom_range(31));
          hi = 5'($urandom_range(31));
          if ($urandom_range(9) != 0 && lo > hi) begin
            tmp = lo; lo = hi; hi = tmp;
          end
          th_in[10*p +: 5]   = lo;
          th_in[10*p+5 +: 5] = hi;
        end
        init    = ($urandom_range(5) == 0);
        errors  = ($urandom_range(39) == 0) ? 5'($urandom_range(31, 1)) : 5'd0;
        empties = ($urandom_range(1) == 0) ? 5'h1F : 5'($urandom);
        model_edge();
        tick();
        check_model($sformatf("rnd%0d", n));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
